angle_frame_tx: RTL



---
 rtl/angle_frame_pkg.sv | 31 +++
 rtl/angle_frame_tx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/angle_frame_pkg.sv
// Shared definitions for the angle-frame transmitter and parser: framing
// constants, byte positions within the 11-byte frame, and the FSM state type.
package angle_frame_pkg;

    localparam logic [7:0] HEADER_BYTE     = 8'h55;
    localparam logic [7:0] FRAME_TYPE_BYTE = 8'h53;
    localparam int         FRAME_LEN       = 11;

    localparam logic [3:0] IDX_HEADER = 4'd0;
    localparam logic [3:0] IDX_TYPE   = 4'd1;
    localparam logic [3:0] ROLL_L     = 4'd2;
    localparam logic [3:0] ROLL_H     = 4'd3;
    localparam logic [3:0] PITCH_L    = 4'd4;
    localparam logic [3:0] PITCH_H    = 4'd5;
    localparam logic [3:0] YAW_L      = 4'd6;
    localparam logic [3:0] YAW_H      = 4'd7;
    localparam logic [3:0] TEMP_L     = 4'd8;
    localparam logic [3:0] TEMP_H     = 4'd9;
    localparam logic [3:0] SUM        = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } frame_state_e;

    // Modulo-256 sum of the two bytes of a 16-bit word.
    function automatic logic [7:0] word_byte_sum(input logic [15:0] w);
        return w[7:0] + w[15:8];
    endfunction

endpackage

// File: rtl/angle_frame_tx.sv
// Angle-frame transmitter: snapshots roll/pitch/yaw/temp on a request and
// streams the 11-byte frame (header, type, four LE words, checksum) out over
// a valid/ready byte handshake. Optional free-running timer issues requests.
module angle_frame_tx
    import angle_frame_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_BYTE,
    parameter logic [7:0]  FRAME_TYPE  = FRAME_TYPE_BYTE,
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               send,
    input  logic signed [15:0] roll,
    input  logic signed [15:0] pitch,
    input  logic signed [15:0] yaw,
    input  logic signed [15:0] temp,
    output logic        [7:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    frame_state_e      state, state_nxt;
    logic [3:0]        idx, idx_nxt;
    logic              start;
    logic              last_xfer;
    logic              pending;
    logic              auto_wrap;
    logic [7:0]        byte_mux;

    logic signed [15:0] roll_p0, pitch_p0, yaw_p0, temp_p0;
    logic        [7:0]  sum_p0;

    // Checksum of bytes 0..9 for a given set of words, carries discarded.
    function automatic logic [7:0] frame_checksum(input logic [15:0] r,
                                                  input logic [15:0] p,
                                                  input logic [15:0] y,
                                                  input logic [15:0] t);
        return HEADER + FRAME_TYPE + word_byte_sum(r) + word_byte_sum(p)
             + word_byte_sum(y) + word_byte_sum(t);
    endfunction

    // Auto-send timer: wraps 0..AUTO_PERIOD-1, absent when AUTO_PERIOD is 0.
    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam int CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_PERIOD - 1);
            logic [CNT_W-1:0] auto_cnt;

            // Free-running period counter.
            always_ff @(posedge clk) begin
                if (rst)
                    auto_cnt <= '0;
                else if (auto_cnt == CNT_LAST)
                    auto_cnt <= '0;
                else
                    auto_cnt <= auto_cnt + 1'b1;
            end

            assign auto_wrap = (auto_cnt == CNT_LAST);
        end else begin : g_no_auto
            assign auto_wrap = 1'b0;
        end
    endgenerate

    // Pending request: set by timer wraps, collapsed to one, cleared when a frame starts.
    always_ff @(posedge clk) begin
        if (rst)
            pending <= 1'b0;
        else if (start)
            pending <= 1'b0;
        else if (auto_wrap)
            pending <= 1'b1;
    end

    // Control registers: FSM state, byte index and the end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            frame_done <= last_xfer;
        end
    end

    // ---- stage p0: frame snapshot and checksum captured at frame start ----
    always_ff @(posedge clk) begin
        if (start) begin
            roll_p0  <= roll;
            pitch_p0 <= pitch;
            yaw_p0   <= yaw;
            temp_p0  <= temp;
            sum_p0   <= frame_checksum(roll, pitch, yaw, temp);
        end
    end

    // Byte selection by frame position, from the snapshot only.
    always_comb begin
        byte_mux = '0;
        case (idx)
            IDX_HEADER: byte_mux = HEADER;
            IDX_TYPE:   byte_mux = FRAME_TYPE;
            ROLL_L:     byte_mux = roll_p0[7:0];
            ROLL_H:     byte_mux = roll_p0[15:8];
            PITCH_L:    byte_mux = pitch_p0[7:0];
            PITCH_H:    byte_mux = pitch_p0[15:8];
            YAW_L:      byte_mux = yaw_p0[7:0];
            YAW_H:      byte_mux = yaw_p0[15:8];
            TEMP_L:     byte_mux = temp_p0[7:0];
            TEMP_H:     byte_mux = temp_p0[15:8];
            SUM:        byte_mux = sum_p0;
            default:    byte_mux = '0;
        endcase
    end

    // Next-state and handshake outputs; index moves only on an accepted byte.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        start     = 1'b0;
        last_xfer = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        case (state)
            ST_IDLE: begin
                if (send || pending) begin
                    start     = 1'b1;
                    state_nxt = ST_SEND;
                    idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = byte_mux;
                if (tx_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = '0;
                        last_xfer = 1'b1;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = tx_valid;

endmodule
